// File: rtl/mem_stage.sv
// mem_stage: EX/MEM and MEM/WB pipeline registers of the MIPS memory stage,
// a req/ready data-memory port, stall generation and a timeout error path.
`default_nettype none

module mem_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic        MemWriteE,
  input  logic [31:0] ALUOutE,
  input  logic [31:0] WriteDataE,
  input  logic [4:0]  WriteRegE,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        MemStall,
  output logic        RegWriteM,
  output logic [4:0]  WriteRegM,
  output logic [31:0] ALUOutM,
  output logic        RegWriteW,
  output logic [4:0]  WriteRegW,
  output logic [31:0] ResultW,
  output logic        MemErr
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;

  logic        MemtoRegM, MemWriteM;
  logic [31:0] WriteDataM;
  logic        MemtoRegW;
  logic [31:0] ALUOutW, ReadDataW;

  logic acc_m, mis_m, timeout, done, err;

  assign acc_m    = MemtoRegM | MemWriteM;
  assign mis_m    = acc_m & (ALUOutM[1:0] != 2'b00);
  assign dmem_req = acc_m & ~mis_m;
  assign dmem_we  = MemWriteM;
  assign dmem_addr  = ALUOutM;
  assign dmem_wdata = WriteDataM;

  // Timeout only fires if the memory has not answered in the final allowed cycle.
  assign timeout  = (state == WAIT) & (cnt == CW'(TIMEOUT)) & ~dmem_ready;
  assign done     = ~acc_m | mis_m | dmem_ready | timeout;
  assign MemStall = acc_m & ~done;
  assign err      = mis_m | timeout;

  assign ResultW  = MemtoRegW ? ReadDataW : ALUOutW;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (dmem_req & ~dmem_ready) begin
          state_next = WAIT;
          cnt_next   = CW'(1);
        end
      end
      WAIT: begin
        if (dmem_ready | timeout) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ALUOutM    <= '0;
      WriteDataM <= '0;
      WriteRegM  <= '0;
    end else if (!MemStall) begin
      RegWriteM  <= RegWriteE;
      MemtoRegM  <= MemtoRegE;
      MemWriteM  <= MemWriteE;
      ALUOutM    <= ALUOutE;
      WriteDataM <= WriteDataE;
      WriteRegM  <= WriteRegE;
    end
  end

  // A faulting access completes without a register write; the error is sticky.
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteW <= 1'b0;
      MemtoRegW <= 1'b0;
      ALUOutW   <= '0;
      ReadDataW <= '0;
      WriteRegW <= '0;
      MemErr    <= 1'b0;
    end else if (MemStall) begin
      RegWriteW <= 1'b0;
    end else begin
      RegWriteW <= RegWriteM & ~err;
      MemtoRegW <= MemtoRegM;
      ALUOutW   <= ALUOutM;
      ReadDataW <= dmem_rdata;
      WriteRegW <= WriteRegM;
      MemErr    <= MemErr | err;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: memory model with programmable wait
// states, scoreboard of expected writebacks, and per-scenario checks.
`default_nettype none

module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteE, MemtoRegE, MemWriteE;
  logic [31:0] ALUOutE, WriteDataE;
  logic [4:0]  WriteRegE;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        MemStall, RegWriteM, RegWriteW, MemErr;
  logic [4:0]  WriteRegM, WriteRegW;
  logic [31:0] ALUOutM, ResultW;

  mem_stage #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .ALUOutE(ALUOutE), .WriteDataE(WriteDataE), .WriteRegE(WriteRegE),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .MemStall(MemStall), .RegWriteM(RegWriteM), .WriteRegM(WriteRegM),
    .ALUOutM(ALUOutM), .RegWriteW(RegWriteW), .WriteRegW(WriteRegW),
    .ResultW(ResultW), .MemErr(MemErr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: answers after wait_cfg unanswered request cycles (-1 = never).
  logic [31:0] mem [logic [31:0]];
  int wait_cfg = 0;
  int seen = 0;
  initial begin
    dmem_ready = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!dmem_req) begin
        dmem_ready = 1'b0;
        seen = 0;
      end else if (seen == wait_cfg) begin
        dmem_ready = 1'b1;
        dmem_rdata = mem.exists(dmem_addr) ? mem[dmem_addr] : 32'h0;
        if (dmem_we) mem[dmem_addr] = dmem_wdata;
        seen = 0;
      end else begin
        dmem_ready = 1'b0;
        seen++;
      end
    end
  end

  // Scoreboard entries: {WriteReg, Result}
  logic [36:0] sb [$];
  int stall_cycles, req_run, req_max, wcount, last_w, w_gap;

  always @(negedge clk) begin
    if (MemStall) stall_cycles++;
    if (dmem_req) begin
      req_run++;
      if (req_run > req_max) req_max = req_run;
    end else begin
      req_run = 0;
    end
    if (RegWriteW) begin
      wcount++;
      w_gap  = cyc - last_w;
      last_w = cyc;
      if (sb.size() == 0) begin
        check("w_unexpected", {31'b0, RegWriteW}, 32'h0);
      end else begin
        logic [36:0] e;
        e = sb.pop_front();
        check("w_reg", {27'b0, WriteRegW}, {27'b0, e[36:32]});
        check("w_result", ResultW, e[31:0]);
      end
    end
  end

  int cap_cyc;

  task automatic clear_stats();
    stall_cycles = 0; req_run = 0; req_max = 0; wcount = 0; w_gap = 0;
  endtask

  task automatic bubble();
    RegWriteE = 0; MemtoRegE = 0; MemWriteE = 0;
    ALUOutE = '0; WriteDataE = '0; WriteRegE = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Presents an op on the E inputs and holds it until the stage accepts it.
  task automatic issue(input logic rw, input logic mtr, input logic mw,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] wr);
    logic st;
    int n;
    RegWriteE = rw; MemtoRegE = mtr; MemWriteE = mw;
    ALUOutE = addr; WriteDataE = wd; WriteRegE = wr;
    st = 1'b1;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      st = MemStall;
      @(posedge clk);
      if (!st) break;
    end
    if (n == 100) check("issue_bound", {31'b0, st}, 32'h0);
    #2;
    cap_cyc = cyc;
    bubble();
  endtask

  initial begin
    int c0;
    bubble();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_req",   {31'b0, dmem_req}, 0);
    check("rst_stall", {31'b0, MemStall}, 0);
    check("rst_err",   {31'b0, MemErr}, 0);
    check("rst_rw_w",  {31'b0, RegWriteW}, 0);
    check("rst_res_w", ResultW, 0);
    check("rst_alu_m", ALUOutM, 0);
    reset = 1'b0;
    idle(1);

    // lw, zero wait
    mem[32'h100] = 32'hCAFEF00D;
    wait_cfg = 0;
    clear_stats();
    sb.push_back({5'd8, 32'hCAFEF00D});
    issue(1, 1, 0, 32'h100, 32'h0, 5'd8);
    c0 = cap_cyc;
    idle(3);
    check("lw0_stall", stall_cycles, 0);
    check("lw0_wcnt", wcount, 1);
    check("lw0_lat", last_w - c0, 1);

    // sw, three wait states
    wait_cfg = 3;
    clear_stats();
    issue(0, 0, 1, 32'h20, 32'h12345678, 5'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("sw_req", {31'b0, dmem_req}, 1);
      check("sw_we", {31'b0, dmem_we}, 1);
      check("sw_addr", dmem_addr, 32'h20);
      check("sw_wdata", dmem_wdata, 32'h12345678);
    end
    idle(3);
    check("sw_stall", stall_cycles, 3);
    check("sw_wcnt", wcount, 0);
    check("sw_mem", mem[32'h20], 32'h12345678);

    // back-to-back loads, one wait each
    mem[32'h0] = 32'h11111111;
    mem[32'h4] = 32'h22222222;
    wait_cfg = 1;
    clear_stats();
    sb.push_back({5'd9, 32'h11111111});
    sb.push_back({5'd10, 32'h22222222});
    issue(1, 1, 0, 32'h0, 32'h0, 5'd9);
    issue(1, 1, 0, 32'h4, 32'h0, 5'd10);
    @(negedge clk);
    check("b2b_addr2", dmem_addr, 32'h4);
    idle(5);
    check("b2b_req_run", req_max, 4);
    check("b2b_wcnt", wcount, 2);
    check("b2b_gap", w_gap, 2);
    check("b2b_stall", stall_cycles, 2);
    check("b2b_noerr", {31'b0, MemErr}, 0);

    // misaligned load
    clear_stats();
    issue(1, 1, 0, 32'h102, 32'h0, 5'd7);
    @(negedge clk);
    check("mis_req", {31'b0, dmem_req}, 0);
    check("mis_stall", {31'b0, MemStall}, 0);
    @(posedge clk);
    @(negedge clk);
    check("mis_rw_w", {31'b0, RegWriteW}, 0);
    check("mis_err", {31'b0, MemErr}, 1);
    idle(3);
    check("mis_err_sticky", {31'b0, MemErr}, 1);
    check("mis_wcnt", wcount, 0);

    reset = 1'b1;
    idle(1);
    check("rst2_err", {31'b0, MemErr}, 0);
    reset = 1'b0;

    // timeout: memory never answers
    wait_cfg = -1;
    clear_stats();
    issue(1, 1, 0, 32'h40, 32'h0, 5'd6);
    idle(8);
    check("to_stall", stall_cycles, 4);
    check("to_req_run", req_max, 5);
    check("to_err", {31'b0, MemErr}, 1);
    check("to_wcnt", wcount, 0);

    // reset during a wait, then a normal load
    wait_cfg = 5;
    issue(1, 1, 0, 32'h8, 32'h0, 5'd5);
    idle(1);
    reset = 1'b1;
    idle(1);
    check("rstw_req", {31'b0, dmem_req}, 0);
    check("rstw_stall", {31'b0, MemStall}, 0);
    check("rstw_err", {31'b0, MemErr}, 0);
    check("rstw_rw_w", {31'b0, RegWriteW}, 0);
    check("rstw_rw_m", {31'b0, RegWriteM}, 0);
    check("rstw_alu_m", ALUOutM, 0);
    reset = 1'b0;
    wait_cfg = 1;
    mem[32'hC] = 32'h33334444;
    clear_stats();
    sb.push_back({5'd12, 32'h33334444});
    issue(1, 1, 0, 32'hC, 32'h0, 5'd12);
    idle(5);
    check("post_rst_wcnt", wcount, 1);
    check("post_rst_stall", stall_cycles, 1);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory stage of the 5-stage MIPS pipeline, directly downstream of the execute stage. It holds the EX/MEM pipeline register, drives a word-wide data-memory port with a req/ready handshake, and stalls the pipeline while an access is outstanding. It also produces the MEM/WB register and the M/W values used by the forwarding unit.

## Interface
- TIMEOUT, 255: max consecutive wait cycles before an access is force-completed as an error (≥2)
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- RegWriteE, MemtoRegE, MemWriteE  in  1 each  control from EX
- ALUOutE  in  32  address / ALU result from EX
- WriteDataE  in  32  forwarded store data from EX
- WriteRegE  in  5  destination register from EX
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  32  word address (= ALUOutM)
- dmem_wdata  out  32  store data (= WriteDataM)
- dmem_ready  in  1  access completes this cycle
- dmem_rdata  in  32  load data, valid when dmem_ready
- MemStall  out  1  to hazard unit: freeze F/D/E and hold M
- RegWriteM  out  1;  WriteRegM  out  5;  ALUOutM  out  32  forwarding taps
- RegWriteW  out  1;  WriteRegW  out  5;  ResultW  out  32  writeback
- MemErr  out  1  sticky error flag

## Operation
- EX/MEM register: reset → all fields 0. MemStall=1 → hold. Otherwise capture the E inputs.
- accM = MemtoRegM | MemWriteM. misM = accM & (ALUOutM[1:0] != 0).
- dmem_req = accM & ~misM, combinational. It stays high while M holds, and it is never withdrawn before ready. dmem_we = MemWriteM.
- FSM, states IDLE and WAIT, with wait counter cnt (width clog2(TIMEOUT+1)):
  - IDLE:
    - dmem_req & ~dmem_ready → WAIT, cnt=1.
    - Otherwise stay in IDLE.
  - WAIT:
    - dmem_ready → IDLE, cnt=0.
    - cnt == TIMEOUT → timeout completion, go to IDLE, cnt=0.
    - Otherwise cnt+1.
- Completion this cycle (done): ~accM, or misM, or dmem_ready, or timeout.
- MemStall = accM & ~done. This is combinational from dmem_ready.
- MEM/WB register: reset → 0.
  - MemStall=1 → bubble: RegWriteW=0, other fields don't care.
  - Otherwise capture RegWriteM, MemtoRegM, ALUOutM, WriteRegM, and ReadData = dmem_rdata.
- Error completion (misM or timeout):
  - No request is issued when misM.
  - The captured RegWrite is forced to 0, so a faulting load does not write.
  - A faulting store has no side effect.
  - MemErr is set and stays set until reset.
- ResultW = MemtoRegW ? ReadDataW : ALUOutW, combinational.

## Timing
- Reset values: every register 0, state IDLE, cnt 0. All outputs 0, including dmem_req, MemStall and MemErr.
- Zero-wait memory (ready in the same cycle as req): no stall. Load data is in ResultW in the next cycle.
- N wait cycles: MemStall is high for N cycles. The W result appears in the cycle after ready.
- Back-to-back memory ops: the second op's req rises in the cycle after the first completes, with no idle gap.
- Timeout: at most TIMEOUT stall cycles, then the access completes with the error path.
- Reset mid-WAIT: next cycle dmem_req=0, state IDLE, MemStall=0. The memory must tolerate an abandoned request.
- dmem_ready while dmem_req=0: ignored.

## Test plan
- lw, zero-wait: E MemtoRegE=1, RegWriteE=1, ALUOutE=0x100, WriteRegE=8; dmem_rdata=0xCAFEF00D with ready in the same cycle → MemStall never high; next cycle RegWriteW=1, WriteRegW=8, ResultW=0xCAFEF00D.
- sw with 3 wait states: addr 0x20, data 0x12345678 → dmem_req/we high, addr 0x20, wdata held stable for 4 cycles; MemStall high for exactly 3 cycles; RegWriteW=0 throughout.
- Back-to-back lw 0x0 then lw 0x4, 1 wait each → req is high for 4 consecutive cycles; the addr changes 0x0→0x4 after the first ready; two W writes, 2 cycles apart.
- Misaligned lw addr 0x102 → dmem_req=0, MemStall=0, next cycle RegWriteW=0, MemErr=1 and stays 1.
- Timeout with TIMEOUT=4 and ready tied to 0 → MemStall high for exactly 4 cycles, then it drops; MemErr=1; no register write.
- Reset asserted in cycle 2 of a wait → next cycle all outputs 0 and state IDLE; a new lw issued after reset completes normally.
